// File: rtl/rsa_pkg.sv
// State encodings and the exponent-bit sequencing rule for the modexp controller.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_BASE,
    ST_PRE_ACC,
    ST_MUL,
    ST_SQR,
    ST_POST,
    ST_REDUCE,
    ST_DONE
  } ModexpState_t;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } MmPhase_t;

  // Where to go once bit k is the current bit: multiply if set, else square,
  // except that the square for the final bit is skipped.
  function automatic ModexpState_t bit_state(input logic exp_bit, input logic last_bit);
    if (exp_bit) return ST_MUL;
    if (last_bit) return ST_POST;
    return ST_SQR;
  endfunction

endpackage

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply modexp: o_out = i_msg^i_exp mod i_modulus, with the
// Montgomery multiplier living outside as a sibling reached through the mm_* handshake.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int MOD_WIDTH = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_msg,
  input  logic [EXP_WIDTH-1:0] i_exp,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out,
  output logic                 mm_i_valid,
  input  logic                 mm_i_ready,
  output logic [MOD_WIDTH-1:0] mm_a,
  output logic [MOD_WIDTH-1:0] mm_b,
  output logic [MOD_WIDTH-1:0] mm_modulus,
  input  logic                 mm_o_valid,
  output logic                 mm_o_ready,
  input  logic [MOD_WIDTH-1:0] mm_out
);

  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(EXP_WIDTH - 1);
  localparam logic [MOD_WIDTH-1:0] ONE = MOD_WIDTH'(1);

  ModexpState_t state_q, state_d;
  MmPhase_t phase_q, phase_d;
  logic [KW-1:0] k_q, k_d, k_inc;
  logic [MOD_WIDTH-1:0] msg_q, mod_q, r2_q, base_q, acc_q, out_q, reduced;
  logic [EXP_WIDTH-1:0] exp_q;
  logic in_mult, mm_done, base_we, acc_we, accept;

  assign k_inc = k_q + KW'(1);
  assign accept = (state_q == ST_IDLE) && i_valid;
  assign in_mult = (state_q == ST_PRE_BASE) || (state_q == ST_PRE_ACC) || (state_q == ST_MUL) ||
                   (state_q == ST_SQR) || (state_q == ST_POST);
  // mm_out may sit in [0, 2n); after the final conversion a single subtract suffices.
  assign reduced = (acc_q >= mod_q) ? acc_q - mod_q : acc_q;

  assign i_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_out = out_q;
  assign mm_modulus = mod_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    k_d = k_q;
    mm_i_valid = 1'b0;
    mm_o_ready = 1'b0;
    mm_a = '0;
    mm_b = '0;
    mm_done = 1'b0;
    base_we = 1'b0;
    acc_we = 1'b0;

    case (state_q)
      ST_PRE_BASE: begin mm_a = msg_q; mm_b = r2_q; end
      ST_PRE_ACC:  begin mm_a = ONE;   mm_b = r2_q; end
      ST_MUL:      begin mm_a = acc_q; mm_b = base_q; end
      ST_SQR:      begin mm_a = base_q; mm_b = base_q; end
      ST_POST:     begin mm_a = acc_q; mm_b = ONE; end
      default: ;
    endcase

    if (in_mult) begin
      if (phase_q == PH_ISSUE) begin
        mm_i_valid = 1'b1;
        if (mm_i_ready) phase_d = PH_WAIT;
      end else begin
        mm_o_ready = 1'b1;
        if (mm_o_valid) begin
          phase_d = PH_ISSUE;
          mm_done = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_PRE_BASE;
          phase_d = PH_ISSUE;
          k_d = '0;
        end
      end
      ST_PRE_BASE: begin
        base_we = mm_done;
        if (mm_done) state_d = ST_PRE_ACC;
      end
      ST_PRE_ACC: begin
        acc_we = mm_done;
        if (mm_done) state_d = bit_state(exp_q[k_q], k_q == K_LAST);
      end
      ST_MUL: begin
        acc_we = mm_done;
        if (mm_done) state_d = (k_q == K_LAST) ? ST_POST : ST_SQR;
      end
      ST_SQR: begin
        base_we = mm_done;
        if (mm_done) begin
          k_d = k_inc;
          state_d = bit_state(exp_q[k_inc], k_inc == K_LAST);
        end
      end
      ST_POST: begin
        acc_we = mm_done;
        if (mm_done) state_d = ST_REDUCE;
      end
      ST_REDUCE: state_d = ST_DONE;
      ST_DONE: if (o_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
      k_q <= '0;
      msg_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      r2_q <= '0;
      base_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      k_q <= k_d;
      if (accept) begin
        msg_q <= i_msg;
        exp_q <= i_exp;
        mod_q <= i_modulus;
        r2_q <= i_r2;
      end
      if (base_we) base_q <= mm_out;
      if (acc_we) acc_q <= mm_out;
      if (state_q == ST_REDUCE) out_q <= reduced;
    end
  end

endmodule
